// File: rtl/vga_timing_gen_if.sv
// Pixel-chain types and the interface that carries one pixel's timing and
// colour from stage to stage.
package vga_pkg;
  localparam int unsigned PXL_X_W = 10;
  localparam int unsigned PXL_Y_W = 9;

  typedef struct packed {
    logic [PXL_X_W-1:0] pxl_x;
    logic [PXL_Y_W-1:0] pxl_y;
    logic [3:0]         red;
    logic [3:0]         green;
    logic [3:0]         blue;
    logic               en;
    logic               hsync;
    logic               vsync;
    logic               active;
  } vga_t;
endpackage

interface vga_timing_gen_if;
  vga_pkg::vga_t t;
  modport master (output t);
  modport slave  (input  t);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: head of the pixel chain. Produces registered sync,
// active-video, pixel coordinates and background colour, plus pixel, line
// and frame strobes and a running frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter int unsigned CLK_DIV     = 2
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   enable,
  input  logic [11:0]            bg_color,
  vga_timing_gen_if.master       vga_chain_out,
  output logic                   pixel_tick,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [15:0]            frame_cnt
);

  localparam int unsigned H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned XW      = $clog2(WIDTH);
  localparam int unsigned YW      = $clog2(HEIGHT);

  logic [DW-1:0] div_cnt;
  logic [HW-1:0] h_cnt, h_next;
  logic [VW-1:0] v_cnt, v_next;
  logic          tick;
  logic          wrap_h;
  logic          new_line;
  logic          new_frame;
  int unsigned   h_i, v_i;
  vga_t          pix_next;

  // Next counter position and the pixel it presents; outputs are built from
  // the post-tick position so the registered pixel matches the new counters.
  always_comb begin
    tick   = enable && (div_cnt == DW'(CLK_DIV - 1));
    wrap_h = (h_cnt == HW'(H_TOTAL - 1));
    h_next = wrap_h ? '0 : h_cnt + 1'b1;
    v_next = v_cnt;
    if (wrap_h) begin
      v_next = (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
    end
    new_line  = (h_next == '0);
    new_frame = new_line && (v_next == '0);
    h_i = 32'(h_next);
    v_i = 32'(v_next);

    pix_next        = '0;
    pix_next.active = (h_i < WIDTH) && (v_i < HEIGHT);
    pix_next.hsync  = ((h_i >= WIDTH + H_FP) && (h_i < WIDTH + H_FP + H_SYNC))
                      ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    pix_next.vsync  = ((v_i >= HEIGHT + V_FP) && (v_i < HEIGHT + V_FP + V_SYNC))
                      ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    if (pix_next.active) begin
      pix_next.pxl_x = PXL_X_W'(h_next[XW-1:0]);
      pix_next.pxl_y = PXL_Y_W'(v_next[YW-1:0]);
      pix_next.red   = bg_color[11:8];
      pix_next.green = bg_color[7:4];
      pix_next.blue  = bg_color[3:0];
    end
  end

  // Pixel divider and raster counters; reset parks them on the last pixel of
  // the frame so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_cnt <= '0;
      h_cnt   <= HW'(H_TOTAL - 1);
      v_cnt   <= VW'(V_TOTAL - 1);
    end else if (enable) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        h_cnt <= h_next;
        v_cnt <= v_next;
      end
    end
  end

  // Registered chain outputs, strobes and frame counter, updated on tick only.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vga_chain_out.t       <= '0;
      vga_chain_out.t.hsync <= ~SYNC_ACTIVE;
      vga_chain_out.t.vsync <= ~SYNC_ACTIVE;
      pixel_tick            <= 1'b0;
      line_start            <= 1'b0;
      frame_start           <= 1'b0;
      frame_cnt             <= '0;
    end else begin
      pixel_tick  <= tick;
      line_start  <= tick && new_line;
      frame_start <= tick && new_frame;
      if (tick) begin
        vga_chain_out.t <= pix_next;
      end
      if (tick && new_frame) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule
